// File: rtl/bus_transaction_scheduler_pkg.sv
// Shared types for the snoop-bus / L2 scheduler: bus ops, FSM states, defaults.
package bus_pkg;
  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SNOOP,
    L2_WAIT,
    RESP
  } sched_state_t;

  localparam int DEFAULT_L2_TIMEOUT = 15;
endpackage

// File: rtl/bus_transaction_scheduler_if.sv
// Cache-controller / snoop / L2 signal bundle around the scheduler.
// master = scheduler side, slave = caches + L2 fabric side.
interface bus_transaction_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_core1;
  logic [1:0]            bus_operation_in1;
  logic [ADDR_WIDTH-1:0] bus_address_in1;
  logic                  req_core2;
  logic [1:0]            bus_operation_in2;
  logic [ADDR_WIDTH-1:0] bus_address_in2;
  logic                  grant_core1;
  logic                  grant_core2;
  logic                  snoop_valid1;
  logic                  snoop_valid2;
  logic [1:0]            snoop_operation;
  logic [ADDR_WIDTH-1:0] snoop_address;
  logic                  snoop_hit1;
  logic [DATA_WIDTH-1:0] snoop_data1;
  logic                  snoop_hit2;
  logic [DATA_WIDTH-1:0] snoop_data2;
  logic                  l2_req;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic                  l2_ready;
  logic [DATA_WIDTH-1:0] l2_data;
  logic                  resp_done1;
  logic                  resp_done2;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_from_cache;
  logic                  resp_error;

  modport master (
    input  req_core1, bus_operation_in1, bus_address_in1,
           req_core2, bus_operation_in2, bus_address_in2,
           snoop_hit1, snoop_data1, snoop_hit2, snoop_data2,
           l2_ready, l2_data,
    output grant_core1, grant_core2, snoop_valid1, snoop_valid2,
           snoop_operation, snoop_address, l2_req, l2_address,
           resp_done1, resp_done2, resp_data, resp_from_cache, resp_error
  );

  modport slave (
    output req_core1, bus_operation_in1, bus_address_in1,
           req_core2, bus_operation_in2, bus_address_in2,
           snoop_hit1, snoop_data1, snoop_hit2, snoop_data2,
           l2_ready, l2_data,
    input  grant_core1, grant_core2, snoop_valid1, snoop_valid2,
           snoop_operation, snoop_address, l2_req, l2_address,
           resp_done1, resp_done2, resp_data, resp_from_cache, resp_error
  );
endinterface

// File: rtl/bus_transaction_scheduler_rr_arbiter2.sv
// Two-way round-robin pick: ptr selects the favoured requester when both are eligible.
module rr_arbiter2 (
  input  logic       ptr,
  input  logic [1:0] elig,
  output logic [1:0] win,
  output logic       win_vld
);
  always_comb begin
    win = elig;
    if (elig == 2'b11) begin
      win      = 2'b00;
      win[ptr] = 1'b1;
    end
  end

  assign win_vld = |elig;
endmodule

// File: rtl/bus_transaction_scheduler.sv
// One-transaction-at-a-time scheduler for the shared snoop bus and L2 port.
// Owner is latched at grant; peer cache is snooped first, L2 is the fallback.
module bus_transaction_scheduler
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int L2_TIMEOUT = DEFAULT_L2_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  bus_transaction_scheduler_if.master bus
);
  localparam int CW = $clog2(L2_TIMEOUT + 1);

  sched_state_t          state, state_nxt;
  logic                  owner, owner_nxt;   // 0 = core1, 1 = core2
  logic                  ptr, ptr_nxt;
  bus_op_t               op_q, op_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  cache_q, cache_nxt;
  logic                  err_q, err_nxt;

  logic [1:0] elig, win;
  logic       win_vld;
  logic                  peer_hit;
  logic [DATA_WIDTH-1:0] peer_data;

  assign elig[0] = bus.req_core1 && (bus.bus_operation_in1 != BUS_NON);
  assign elig[1] = bus.req_core2 && (bus.bus_operation_in2 != BUS_NON);

  rr_arbiter2 u_arb (
    .ptr    (ptr),
    .elig   (elig),
    .win    (win),
    .win_vld(win_vld)
  );

  assign peer_hit  = owner ? bus.snoop_hit1  : bus.snoop_hit2;
  assign peer_data = owner ? bus.snoop_data1 : bus.snoop_data2;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    op_nxt    = op_q;
    addr_nxt  = addr_q;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;
    cache_nxt = cache_q;
    err_nxt   = err_q;
    case (state)
      IDLE: if (win_vld) begin
        owner_nxt = win[1];
        op_nxt    = bus_op_t'(win[1] ? bus.bus_operation_in2 : bus.bus_operation_in1);
        addr_nxt  = win[1] ? bus.bus_address_in2 : bus.bus_address_in1;
        state_nxt = SNOOP;
      end
      SNOOP: begin
        if (op_q == BUS_UPGR) begin
          state_nxt = RESP;
        end else if (peer_hit) begin
          data_nxt  = peer_data;
          cache_nxt = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt   = '0;
          state_nxt = L2_WAIT;
        end
      end
      L2_WAIT: begin
        cnt_nxt = cnt_q + 1'b1;
        // ready wins over a timeout landing on the same cycle
        if (bus.l2_ready) begin
          data_nxt  = bus.l2_data;
          state_nxt = RESP;
        end else if (cnt_q == CW'(L2_TIMEOUT - 1)) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        ptr_nxt   = ~owner;
        op_nxt    = BUS_NON;
        addr_nxt  = '0;
        data_nxt  = '0;
        cache_nxt = 1'b0;
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      op_q    <= BUS_NON;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      cache_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      op_q    <= op_nxt;
      addr_q  <= addr_nxt;
      cnt_q   <= cnt_nxt;
      data_q  <= data_nxt;
      cache_q <= cache_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.grant_core1     = (state != IDLE) && !owner;
  assign bus.grant_core2     = (state != IDLE) &&  owner;
  assign bus.snoop_valid1    = (state == SNOOP) &&  owner;
  assign bus.snoop_valid2    = (state == SNOOP) && !owner;
  assign bus.snoop_operation = op_q;
  assign bus.snoop_address   = addr_q;
  assign bus.l2_req          = (state == L2_WAIT);
  assign bus.l2_address      = (state == L2_WAIT) ? addr_q : '0;
  assign bus.resp_done1      = (state == RESP) && !owner;
  assign bus.resp_done2      = (state == RESP) &&  owner;
  assign bus.resp_data       = data_q;
  assign bus.resp_from_cache = cache_q;
  assign bus.resp_error      = err_q;
endmodule

// File: tb/tb_bus_transaction_scheduler.sv
// Directed bench for bus_transaction_scheduler with hand-computed expectations.
module tb_bus_transaction_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_transaction_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif();

  bus_transaction_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .L2_TIMEOUT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  // {grant1, grant2, sv1, sv2, l2_req, done1, done2, from_cache, error}
  logic [8:0] flags;
  assign flags = {bif.grant_core1, bif.grant_core2, bif.snoop_valid1, bif.snoop_valid2,
                  bif.l2_req, bif.resp_done1, bif.resp_done2, bif.resp_from_cache,
                  bif.resp_error};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bif.req_core1 = 0; bif.bus_operation_in1 = 2'b00; bif.bus_address_in1 = '0;
    bif.req_core2 = 0; bif.bus_operation_in2 = 2'b00; bif.bus_address_in2 = '0;
    bif.snoop_hit1 = 0; bif.snoop_data1 = '0;
    bif.snoop_hit2 = 0; bif.snoop_data2 = '0;
    bif.l2_ready = 0; bif.l2_data = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_flags"}, flags, 9'h000);
    chk({tag, "_sop"}, bif.snoop_operation, 2'b11);
    chk({tag, "_sadr"}, bif.snoop_address, 32'h0);
    chk({tag, "_l2a"}, bif.l2_address, 32'h0);
    chk({tag, "_data"}, bif.resp_data, 32'h0);
  endtask

  logic [1:0] exp_g [9] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
  int  l2_cycles;
  bit  done_seen;
  logic [31:0] done_data;
  logic        done_err;

  initial begin
    quiet();
    reset = 1;
    step(); step();
    chk_reset_outs("reset");
    reset = 0;

    // core1 BusRd, peer hit
    bif.req_core1 = 1; bif.bus_operation_in1 = 2'b00; bif.bus_address_in1 = 32'h100;
    bif.snoop_hit2 = 1; bif.snoop_data2 = 32'hDEAD_BEEF;
    step();
    chk("t1_snoop_flags", flags, 9'b1_0_0_1_0_0_0_0_0);
    chk("t1_sadr", bif.snoop_address, 32'h100);
    chk("t1_sop", bif.snoop_operation, 2'b00);
    step();
    chk("t1_resp_flags", flags, 9'b1_0_0_0_0_1_0_1_0);
    chk("t1_resp_data", bif.resp_data, 32'hDEAD_BEEF);
    quiet();
    step();
    chk("t1_idle_flags", flags, 9'h000);
    chk("t1_idle_data", bif.resp_data, 32'h0);

    // core2 BusRdX, snoop miss, L2 ready 3 cycles after l2_req
    bif.req_core2 = 1; bif.bus_operation_in2 = 2'b10; bif.bus_address_in2 = 32'h200;
    step();
    chk("t2_snoop_flags", flags, 9'b0_1_1_0_0_0_0_0_0);
    chk("t2_sop", bif.snoop_operation, 2'b10);
    step();
    chk("t2_l2_flags", flags, 9'b0_1_0_0_1_0_0_0_0);
    chk("t2_l2_addr", bif.l2_address, 32'h200);
    step(); step(); step();
    chk("t2_l2_still", bif.l2_req, 1'b1);
    bif.l2_ready = 1; bif.l2_data = 32'h1234_5678;
    step();
    chk("t2_resp_flags", flags, 9'b0_1_0_0_0_0_1_0_0);
    chk("t2_resp_data", bif.resp_data, 32'h1234_5678);
    quiet();
    step();
    chk("t2_idle_flags", flags, 9'h000);

    // both cores continuously from reset; grants alternate
    bif.req_core1 = 1; bif.bus_operation_in1 = 2'b00; bif.bus_address_in1 = 32'h10;
    bif.req_core2 = 1; bif.bus_operation_in2 = 2'b00; bif.bus_address_in2 = 32'h20;
    bif.snoop_hit1 = 1; bif.snoop_data1 = 32'h1111;
    bif.snoop_hit2 = 1; bif.snoop_data2 = 32'h2222;
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t3_grant_c%0d", i + 1), {bif.grant_core1, bif.grant_core2}, exp_g[i]);
      chk($sformatf("t3_overlap_c%0d", i + 1), bif.grant_core1 & bif.grant_core2, 1'b0);
    end
    quiet();
    step();

    // core1 BusUpgr with peer hit: no L2 traffic
    bif.req_core1 = 1; bif.bus_operation_in1 = 2'b01; bif.bus_address_in1 = 32'h300;
    bif.snoop_hit2 = 1; bif.snoop_data2 = 32'hAAAA_5555;
    step();
    chk("t4_snoop_flags", flags, 9'b1_0_0_1_0_0_0_0_0);
    chk("t4_sop", bif.snoop_operation, 2'b01);
    step();
    chk("t4_done1", bif.resp_done1, 1'b1);
    chk("t4_l2_req", bif.l2_req, 1'b0);
    quiet();
    step();
    chk("t4_idle_flags", flags, 9'h000);

    // core1 BusRd miss, L2 never ready: timeout after 15 l2_req cycles
    bif.req_core1 = 1; bif.bus_operation_in1 = 2'b00; bif.bus_address_in1 = 32'h500;
    l2_cycles = 0; done_seen = 0; done_data = 'x; done_err = 1'bx;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      step();
      if (bif.l2_req) l2_cycles++;
      if (bif.resp_done1) begin
        done_seen = 1; done_data = bif.resp_data; done_err = bif.resp_error;
      end
    end
    chk("t5_done_seen", done_seen, 1'b1);
    chk("t5_l2_cycles", l2_cycles, 15);
    chk("t5_error", done_err, 1'b1);
    chk("t5_data", done_data, 32'h0);
    quiet();
    step();
    chk("t5_idle_flags", flags, 9'h000);

    // reset during L2_WAIT, then a BusNoN request that must never be granted
    bif.req_core1 = 1; bif.bus_operation_in1 = 2'b00; bif.bus_address_in1 = 32'h400;
    step(); step();
    chk("t6_in_l2", bif.l2_req, 1'b1);
    step(); step();
    reset = 1;
    step();
    chk_reset_outs("t6_rst_a");
    step();
    chk_reset_outs("t6_rst_b");
    reset = 0;
    bif.bus_operation_in1 = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t6_non_c%0d", i), flags, 9'h000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_transaction_scheduler.md
Name: bus_transaction_scheduler

Overview:
Registered, FSM-based scheduler for the shared snoop bus and L2 port used by the two L1 data caches.
- Arbitrates round-robin between core1 and core2.
- Holds a grant for the full transaction.
- Broadcasts the request as a snoop to the other core, then falls back to L2 on a snoop miss.
- Returns a single-cycle completion to the owner.
- Sits between the two cache controllers and the L2/bus fabric, sequencing one bus transaction at a time.

Parameters:
ADDR_WIDTH, 32, bus/L2 address width
DATA_WIDTH, 32, bus/L2 data width
L2_TIMEOUT, 15, max cycles waiting for l2_ready before error completion (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_core1  in  1  core1 requests bus; held until resp_done1
bus_operation_in1  in  2  core1 op: 00 BusRd, 01 BusUpgr, 10 BusRdX, 11 BusNoN
bus_address_in1  in  ADDR_WIDTH  core1 address
req_core2  in  1  core2 request
bus_operation_in2  in  2  core2 op
bus_address_in2  in  ADDR_WIDTH  core2 address
grant_core1  out  1  core1 owns bus
grant_core2  out  1  core2 owns bus
snoop_valid1  out  1  snoop presented to core1 (core2 is owner)
snoop_valid2  out  1  snoop presented to core2 (core1 is owner)
snoop_operation  out  2  latched op of owner
snoop_address  out  ADDR_WIDTH  latched address of owner
snoop_hit1  in  1  core1 holds line (valid same cycle as snoop_valid1)
snoop_data1  in  DATA_WIDTH  core1 line data
snoop_hit2  in  1  core2 holds line
snoop_data2  in  DATA_WIDTH  core2 line data
l2_req  out  1  L2 read request, level-held until l2_ready
l2_address  out  ADDR_WIDTH  L2 address
l2_ready  in  1  L2 data valid
l2_data  in  DATA_WIDTH  L2 read data
resp_done1  out  1  one-cycle completion pulse to core1
resp_done2  out  1  one-cycle completion pulse to core2
resp_data  out  DATA_WIDTH  data for the completing core
resp_from_cache  out  1  data came from the peer cache
resp_error  out  1  L2 timeout

Behaviour:
- Reset: state IDLE, priority pointer = core1. All outputs 0 except snoop_operation = 2'b11. Reset mid-transaction aborts with no resp_done pulse.
- Eligibility: a core is eligible when its req is high and its op != 11. A BusNoN request is never granted.
- States: IDLE, SNOOP, L2_WAIT, RESP. All outputs are registered or decoded from registered state; there is no combinational path from req to grant.
- IDLE (cycle N):
  - Only one core eligible → that core wins.
  - Both eligible → the priority pointer wins.
  - On a winner: latch owner/op/address; go to SNOOP in cycle N+1 with grant_owner=1.
- SNOOP (one cycle): snoop_valid of the non-owner = 1; snoop_operation and snoop_address are driven from the latches.
  - BusUpgr → RESP, regardless of hit.
  - BusRd/BusRdX with peer hit → capture the peer's snoop_data; resp_from_cache=1; go to RESP.
  - Otherwise → L2_WAIT.
- L2_WAIT: l2_req=1 and l2_address=latched address; the counter increments each cycle.
  - l2_ready=1 → capture l2_data; go to RESP.
  - Counter reaches L2_TIMEOUT without ready → resp_error=1, resp_data=0; go to RESP.
  - l2_ready takes priority over timeout in the same cycle.
- RESP (one cycle): resp_done_owner=1 with resp_data, resp_from_cache and resp_error valid, and grant still high. Then go to IDLE, flip the priority pointer to the non-owner, and clear the flags.
- Latency:
  - Snoop hit or BusUpgr: resp_done 2 cycles after the first IDLE cycle seeing req.
  - L2 path: resp_done 1 cycle after the l2_ready cycle.
  - Grant drops 1 cycle after resp_done; the next grant comes ≥2 cycles after resp_done.
- Owner deasserting req mid-transaction is ignored; the transaction completes.
- Requester inputs are not sampled after the grant latch.
- Counter width is $clog2(L2_TIMEOUT+1). The counter clears on entry to L2_WAIT.

Decomposition:
- Shared package bus_pkg:
  - bus_op_t enum (BUS_RD=2'b00, BUS_UPGR=2'b01, BUS_RDX=2'b10, BUS_NON=2'b11).
  - sched_state_t enum (IDLE, SNOOP, L2_WAIT, RESP).
  - DEFAULT_L2_TIMEOUT constant.
- One sub-module, rr_arbiter2: 2-way round-robin pick. It takes the pointer and the two eligible bits, and outputs a one-hot winner plus a valid bit.

Test Plan:
- Reset then core1 BusRd 0x100 alone, snoop_hit2=1, snoop_data2=0xDEAD_BEEF → grant_core1 at +1, snoop_valid2 at +1, resp_done1 at +2 with resp_data=0xDEAD_BEEF and resp_from_cache=1.
- core2 BusRdX 0x200, snoop miss, l2_ready asserted 3 cycles after l2_req with l2_data=0x1234_5678 → resp_done2 1 cycle later, resp_data=0x1234_5678, resp_from_cache=0, resp_error=0.
- Both cores request BusRd continuously from reset → grants alternate core1, core2, core1; no overlapping grants.
- core1 BusUpgr 0x300 with snoop_hit2=1 → resp_done1 at +2, no l2_req ever asserted.
- core1 BusRd, snoop miss, l2_ready never asserted → l2_req high for exactly 15 cycles, then resp_done1 with resp_error=1 and resp_data=0.
- reset asserted during L2_WAIT; also core1 requesting with op=11 → all outputs return to reset values with no resp_done pulse; the op=11 request is never granted.
